// File: rtl/exc_pkg.sv
// exc_pkg: shared states, cause codes and default vector constants for the exception controller.
package exc_pkg;
  typedef enum logic [2:0] {IDLE, FLUSH, REDIRECT, HANDLER, RETURN, HALT} state_t;
  typedef enum logic [2:0] {
    CAUSE_NONE,
    CAUSE_STACK_OVERFLOW,
    CAUSE_STACK_UNDERFLOW,
    CAUSE_INVALID_OPCODE,
    CAUSE_DIV_ZERO,
    CAUSE_IMEM_RANGE,
    CAUSE_DMEM_RANGE
  } cause_t;
  localparam logic [31:0] DEFAULT_VECTOR_BASE = 32'h0000_0100;
  localparam int unsigned DEFAULT_VECTOR_SHIFT = 4;
  localparam logic [31:0] DEFAULT_RETURN_OFFSET = 32'd1;
endpackage

// File: rtl/exception_controller.sv
// exception_controller: flushes the pipeline, vectors to a handler and returns, halting on a nested fault.
module exception_controller
  import exc_pkg::*;
#(
  parameter logic [31:0] VECTOR_BASE = DEFAULT_VECTOR_BASE,
  parameter int unsigned VECTOR_SHIFT = DEFAULT_VECTOR_SHIFT,
  parameter logic [31:0] RETURN_OFFSET = DEFAULT_RETURN_OFFSET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_in,
  input  logic        exc_id_in,
  input  logic        exc_ex_in,
  input  logic        exc_mem_in,
  input  logic [2:0]  cause_in,
  input  logic [31:0] epc_in,
  input  logic        rti_in,
  output logic        flush_ifid_out,
  output logic        flush_idex_out,
  output logic        flush_exmem_out,
  output logic        flush_memwb_out,
  output logic        stall_out,
  output logic        pc_load_out,
  output logic [31:0] pc_target_out,
  output logic        in_handler_out,
  output logic [2:0]  cause_saved_out,
  output logic [31:0] epc_saved_out,
  output logic        double_fault_out,
  output logic [7:0]  exc_count_out
);
  state_t state;
  logic [3:0] origin_flush;
  logic [3:0] flush;
  // An exception with no origin flag falls back to the widest (MEM) flush.
  always_comb begin
    origin_flush = exc_mem_in ? 4'b1111 : exc_ex_in ? 4'b0111 : exc_id_in ? 4'b0011 : 4'b1111;
    flush = state == HALT ? 4'b1111 :
            state == RETURN ? 4'b0011 :
            (state == IDLE && exc_in) ? origin_flush : 4'b0000;
    {flush_memwb_out, flush_exmem_out, flush_idex_out, flush_ifid_out} = flush;
  end
  assign stall_out = state == FLUSH || state == HALT;
  assign pc_load_out = state == REDIRECT || state == RETURN;
  assign pc_target_out = state == REDIRECT ? VECTOR_BASE + ({29'd0, cause_saved_out} << VECTOR_SHIFT) :
                         state == RETURN ? epc_saved_out + RETURN_OFFSET : 32'd0;
  assign in_handler_out = state == REDIRECT || state == HANDLER || state == RETURN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cause_saved_out <= 3'd0;
      epc_saved_out <= 32'd0;
      exc_count_out <= 8'd0;
      double_fault_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (exc_in) begin
          state <= FLUSH;
          exc_count_out <= exc_count_out == 8'hFF ? 8'hFF : exc_count_out + 8'd1;
        end
        FLUSH: begin
          cause_saved_out <= cause_in;
          epc_saved_out <= epc_in;
          state <= REDIRECT;
        end
        REDIRECT, HANDLER, RETURN: if (exc_in) begin
          double_fault_out <= 1'b1;
          state <= HALT;
        end else begin
          state <= state == REDIRECT ? HANDLER : state == RETURN ? IDLE : rti_in ? RETURN : HANDLER;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_exception_controller.sv
// tb_exception_controller: directed and randomized checks against a cycle-phase model of the exception flow.
module tb_exception_controller;
  logic clk = 0, reset = 1, exc_in = 0, exc_id_in = 0, exc_ex_in = 0, exc_mem_in = 0, rti_in = 0;
  logic [2:0] cause_in = 0;
  logic [31:0] epc_in = 0;
  logic flush_ifid_out, flush_idex_out, flush_exmem_out, flush_memwb_out;
  logic stall_out, pc_load_out, in_handler_out, double_fault_out;
  logic [31:0] pc_target_out, epc_saved_out;
  logic [2:0] cause_saved_out;
  logic [7:0] exc_count_out;
  int n_checks = 0, n_fail = 0;

  exception_controller dut (
    .clk(clk), .reset(reset), .exc_in(exc_in), .exc_id_in(exc_id_in), .exc_ex_in(exc_ex_in),
    .exc_mem_in(exc_mem_in), .cause_in(cause_in), .epc_in(epc_in), .rti_in(rti_in),
    .flush_ifid_out(flush_ifid_out), .flush_idex_out(flush_idex_out),
    .flush_exmem_out(flush_exmem_out), .flush_memwb_out(flush_memwb_out),
    .stall_out(stall_out), .pc_load_out(pc_load_out), .pc_target_out(pc_target_out),
    .in_handler_out(in_handler_out), .cause_saved_out(cause_saved_out),
    .epc_saved_out(epc_saved_out), .double_fault_out(double_fault_out),
    .exc_count_out(exc_count_out)
  );

  always #5 clk = ~clk;

  // Model: ticks counts cycles since an exception was accepted (1 = flush, 2 = redirect, 3 = handler).
  bit m_on = 0, m_halted = 0, m_df = 0, m_ret = 0;
  int ticks = 0, m_cnt = 0;
  logic [2:0] m_cause = 0;
  logic [31:0] m_epc = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_on <= 1; m_halted <= 0; m_df <= 0; m_ret <= 0; ticks <= 0; m_cnt <= 0; m_cause <= 0; m_epc <= 0;
    end else if (!m_halted) begin
      if (m_ret) begin
        if (exc_in) begin m_halted <= 1; m_df <= 1; end
        m_ret <= 0; ticks <= 0;
      end else if (ticks == 0) begin
        if (exc_in) begin ticks <= 1; m_cnt <= (m_cnt >= 255) ? 255 : m_cnt + 1; end
      end else if (ticks == 1) begin
        m_cause <= cause_in; m_epc <= epc_in; ticks <= 2;
      end else if (exc_in) begin
        m_halted <= 1; m_df <= 1; ticks <= 0;
      end else if (ticks >= 3 && rti_in) m_ret <= 1;
      else if (ticks < 3) ticks <= ticks + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flush_vec();
    return {28'd0, flush_memwb_out, flush_exmem_out, flush_idex_out, flush_ifid_out};
  endfunction

  always @(negedge clk) begin
    int nf;
    logic [3:0] ef;
    logic [31:0] et;
    if (m_on) begin
      nf = exc_mem_in ? 4 : exc_ex_in ? 3 : exc_id_in ? 2 : 4;
      nf = m_halted ? 4 : m_ret ? 2 : (ticks == 0 && exc_in) ? nf : 0;
      for (int k = 0; k < 4; k++) ef[k] = k < nf;
      et = m_ret ? m_epc + 32'd1 : ticks == 2 ? 32'h100 + 32'(m_cause) * 32'd16 : 32'd0;
      chk("model.flush", flush_vec(), {28'd0, ef});
      chk("model.stall", 32'(stall_out), 32'(m_halted || ticks == 1));
      chk("model.pc_load", 32'(pc_load_out), 32'(m_ret || ticks == 2));
      chk("model.pc_target", pc_target_out, et);
      chk("model.in_handler", 32'(in_handler_out), 32'(m_ret || ticks >= 2));
      chk("model.cause_saved", 32'(cause_saved_out), 32'(m_cause));
      chk("model.epc_saved", epc_saved_out, m_epc);
      chk("model.double_fault", 32'(double_fault_out), 32'(m_df));
      chk("model.exc_count", 32'(exc_count_out), 32'(m_cnt));
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] f, input logic s, input logic p,
                            input logic [31:0] t, input logic h, input logic [7:0] c);
    @(negedge clk);
    chk({nm, ".flush"}, flush_vec(), {28'd0, f});
    chk({nm, ".stall"}, 32'(stall_out), 32'(s));
    chk({nm, ".pc_load"}, 32'(pc_load_out), 32'(p));
    chk({nm, ".pc_target"}, pc_target_out, t);
    chk({nm, ".in_handler"}, 32'(in_handler_out), 32'(h));
    chk({nm, ".exc_count"}, 32'(exc_count_out), 32'(c));
  endtask

  initial begin
    int o;
    reset = 1; nxt(); nxt();
    reset = 0;
    expect_out("reset", 4'h0, 0, 0, 0, 0, 0);
    nxt(); exc_in = 1; exc_ex_in = 1; cause_in = 3'd4; epc_in = 32'h20;
    expect_out("ex_idle", 4'b0111, 0, 0, 0, 0, 0);
    nxt(); exc_in = 0; exc_ex_in = 0;
    expect_out("ex_flush", 4'h0, 1, 0, 0, 0, 1);
    nxt();
    expect_out("ex_redirect", 4'h0, 0, 1, 32'h140, 1, 1);
    nxt(); rti_in = 1;
    expect_out("ex_handler", 4'h0, 0, 0, 0, 1, 1);
    chk("ex_handler.epc_saved", epc_saved_out, 32'h20);
    chk("ex_handler.cause_saved", 32'(cause_saved_out), 32'd4);
    nxt(); rti_in = 0;
    expect_out("rti_return", 4'b0011, 0, 1, 32'h21, 1, 1);
    nxt(); exc_in = 1; exc_id_in = 1; exc_mem_in = 1; cause_in = 3'd2; epc_in = 32'h40;
    expect_out("id_mem_idle", 4'hF, 0, 0, 0, 0, 1);
    nxt(); exc_in = 0; exc_id_in = 0; exc_mem_in = 0;
    expect_out("id_mem_flush", 4'h0, 1, 0, 0, 0, 2);
    nxt();
    expect_out("id_mem_redirect", 4'h0, 0, 1, 32'h120, 1, 2);
    nxt(); exc_in = 1; exc_mem_in = 1; rti_in = 1;
    expect_out("nested_handler", 4'h0, 0, 0, 0, 1, 2);
    nxt(); exc_in = 0; exc_mem_in = 0; rti_in = 0;
    expect_out("halt", 4'hF, 1, 0, 0, 0, 2);
    chk("halt.double_fault", 32'(double_fault_out), 32'd1);
    repeat (5) begin
      nxt(); exc_in = 1'($urandom); rti_in = 1'($urandom);
      expect_out("halt_hold", 4'hF, 1, 0, 0, 0, 2);
    end
    nxt(); exc_in = 0; rti_in = 0; reset = 1;
    nxt(); reset = 0;
    expect_out("halt_reset", 4'h0, 0, 0, 0, 0, 0);
    chk("halt_reset.double_fault", 32'(double_fault_out), 32'd0);
    nxt(); exc_in = 1; exc_ex_in = 1; cause_in = 3'd6; epc_in = 32'h1234;
    nxt(); exc_in = 0; exc_ex_in = 0;
    nxt(); reset = 1;
    expect_out("redirect_pre_reset", 4'h0, 0, 1, 32'h160, 1, 1);
    nxt(); reset = 0;
    expect_out("redirect_reset", 4'h0, 0, 0, 0, 0, 0);
    chk("redirect_reset.epc_saved", epc_saved_out, 32'd0);
    nxt();
    expect_out("redirect_reset2", 4'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) begin
      nxt(); exc_in = 1; cause_in = 3'(i % 6 + 1); epc_in = 32'(i);
      if (i == 0) expect_out("no_origin", 4'hF, 0, 0, 0, 0, 0);
      nxt(); exc_in = 0;
      nxt();
      nxt(); rti_in = 1;
      nxt(); rti_in = 0;
    end
    nxt();
    expect_out("saturate", 4'h0, 0, 0, 0, 0, 8'd255);
    for (int i = 0; i < 3000; i++) begin
      nxt();
      reset = m_halted ? ($urandom % 6 == 0) : ($urandom % 300 == 0);
      exc_in = $urandom % 5 == 0;
      o = $urandom % 4;
      exc_id_in = o == 1; exc_ex_in = o == 2; exc_mem_in = o == 3;
      cause_in = 3'($urandom_range(1, 6));
      epc_in = $urandom;
      rti_in = $urandom % 3 == 0;
    end
    nxt(); reset = 0; exc_in = 0; rti_in = 0;
    nxt(); nxt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
